// File: rtl/fifo_unload_fsm_tmr.sv
// fifo_unload_fsm_tmr
// ---------------------------------------------------------------------------
// Read-side controller for the event sample FIFO (first-word-fall-through).
// A START pulse unloads one event: NCHAN words per sample for samples
// 0..SAMP_MAX. Each word is popped into a registered valid/ready output
// stage and tagged with its channel and sample index. LAST marks the final
// word and DONE pulses once that word has been accepted downstream.
//
// Control state (FSM state, channel/sample counters, latched SAMP_MAX,
// DOUT_VALID, LAST, DONE and the error counter) is held in three copies.
// All three copies take their next value from the majority-voted current
// values, so a single upset copy is outvoted and rewritten on the next clock.
// Each cycle where any copy disagrees bumps TMR_ERR_COUNT (wraps at 16'hFFFF).
// The data word and the index output registers are single copy; they are
// loaded from voted counter values.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, SAMP_MAX   event request; SAMP_MAX latched when leaving IDLE
//   FIFO_EMPTY/DOUT   FIFO status and head word (FWFT)
//   RDENA             FIFO pop strobe (combinational)
//   DOUT, DOUT_VALID  output word and its valid flag
//   DOUT_READY        downstream accepts DOUT this cycle
//   CHAN_IDX/SAMP_IDX index tags of the word in DOUT
//   LAST, DONE, BUSY  end-of-event marker, completion pulse, not-idle flag
//   TMR_ERR_COUNT     count of cycles with a replica disagreement
//
// Handshake: a word transfers on every clock where DOUT_VALID & DOUT_READY.
// DOUT and its tags are stable while DOUT_VALID=1 and DOUT_READY=0.
// ---------------------------------------------------------------------------
module fifo_unload_fsm_tmr #(
  parameter int DW    = 16,
  parameter int NCHAN = 6,
  parameter int SW    = 7
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [SW-1:0] SAMP_MAX,
  input  logic          FIFO_EMPTY,
  input  logic [DW-1:0] FIFO_DOUT,
  output logic          RDENA,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [2:0]    CHAN_IDX,
  output logic [SW-1:0] SAMP_IDX,
  output logic          LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   TMR_ERR_COUNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [2:0] CHAN_LAST = 3'(NCHAN - 1);

  // Triplicated control registers, copy index in the outer dimension.
  logic [2:0][1:0]    state_q, state_d;
  logic [2:0][2:0]    chan_q,  chan_d;
  logic [2:0][SW-1:0] samp_q,  samp_d;
  logic [2:0][SW-1:0] max_q,   max_d;
  logic [2:0]         valid_q, valid_d;
  logic [2:0]         last_q,  last_d;
  logic [2:0]         done_q,  done_d;
  logic [2:0][15:0]   err_q,   err_d;

  // Single-copy output data path.
  logic [DW-1:0] dout_q,     dout_d;
  logic [2:0]    chan_idx_q, chan_idx_d;
  logic [SW-1:0] samp_idx_q, samp_idx_d;

  // Voted values; state_v is the FSM state seen by all logic and probes.
  state_e        state_v;
  logic [2:0]    chan_v;
  logic [SW-1:0] samp_v;
  logic [SW-1:0] max_v;
  logic          valid_v;
  logic          last_v;
  logic          done_v;
  logic [15:0]   err_v;

  logic tmr_mismatch;
  logic stage_free;
  logic pop;
  logic final_word;
  logic accept;

  assign state_v = state_e'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                            (state_q[1] & state_q[2]));
  assign chan_v  = (chan_q[0] & chan_q[1]) | (chan_q[0] & chan_q[2]) | (chan_q[1] & chan_q[2]);
  assign samp_v  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign max_v   = (max_q[0] & max_q[1]) | (max_q[0] & max_q[2]) | (max_q[1] & max_q[2]);
  assign valid_v = (valid_q[0] & valid_q[1]) | (valid_q[0] & valid_q[2]) |
                   (valid_q[1] & valid_q[2]);
  assign last_v  = (last_q[0] & last_q[1]) | (last_q[0] & last_q[2]) | (last_q[1] & last_q[2]);
  assign done_v  = (done_q[0] & done_q[1]) | (done_q[0] & done_q[2]) | (done_q[1] & done_q[2]);
  assign err_v   = (err_q[0] & err_q[1]) | (err_q[0] & err_q[2]) | (err_q[1] & err_q[2]);

  // Any copy that differs from another in any bit flags the current cycle.
  assign tmr_mismatch = (state_q[0] != state_q[1]) || (state_q[0] != state_q[2]) ||
                        (chan_q[0]  != chan_q[1])  || (chan_q[0]  != chan_q[2])  ||
                        (samp_q[0]  != samp_q[1])  || (samp_q[0]  != samp_q[2])  ||
                        (max_q[0]   != max_q[1])   || (max_q[0]   != max_q[2])   ||
                        (valid_q[0] != valid_q[1]) || (valid_q[0] != valid_q[2]) ||
                        (last_q[0]  != last_q[1])  || (last_q[0]  != last_q[2])  ||
                        (done_q[0]  != done_q[1])  || (done_q[0]  != done_q[2])  ||
                        (err_q[0]   != err_q[1])   || (err_q[0]   != err_q[2]);

  assign stage_free = ~valid_v | DOUT_READY;
  assign pop        = (state_v == READ) & ~FIFO_EMPTY & stage_free;
  assign final_word = (chan_v == CHAN_LAST) && (samp_v == max_v);
  assign accept     = valid_v & DOUT_READY;

  // Per-copy next-value logic, every copy fed from the voted values.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_v;
      chan_d[i]  = chan_v;
      samp_d[i]  = samp_v;
      max_d[i]   = max_v;
      valid_d[i] = valid_v;
      last_d[i]  = last_v;
      done_d[i]  = 1'b0;
      err_d[i]   = err_v + 16'(tmr_mismatch);

      case (state_v)
        IDLE: begin
          if (START) begin
            state_d[i] = READ;
            chan_d[i]  = '0;
            samp_d[i]  = '0;
            max_d[i]   = SAMP_MAX;
          end
        end
        READ: begin
          if (pop) begin
            if (final_word) state_d[i] = DRAIN;
            if (chan_v == CHAN_LAST) begin
              chan_d[i] = '0;
              // The sample counter stops at the latched max.
              if (!final_word) samp_d[i] = samp_v + SW'(1);
            end else begin
              chan_d[i] = chan_v + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            state_d[i] = IDLE;
            done_d[i]  = 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase

      if (pop) begin
        valid_d[i] = 1'b1;
        last_d[i]  = final_word;
      end else if (accept) begin
        valid_d[i] = 1'b0;
        last_d[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    dout_d     = dout_q;
    chan_idx_d = chan_idx_q;
    samp_idx_d = samp_idx_q;
    if (pop) begin
      dout_d     = FIFO_DOUT;
      chan_idx_d = chan_v;
      samp_idx_d = samp_v;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= '0;
      chan_q     <= '0;
      samp_q     <= '0;
      max_q      <= '0;
      valid_q    <= '0;
      last_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      dout_q     <= '0;
      chan_idx_q <= '0;
      samp_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      samp_q     <= samp_d;
      max_q      <= max_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      chan_idx_q <= chan_idx_d;
      samp_idx_q <= samp_idx_d;
    end
  end

  assign RDENA         = pop;
  assign DOUT          = dout_q;
  assign DOUT_VALID    = valid_v;
  assign CHAN_IDX      = chan_idx_q;
  assign SAMP_IDX      = samp_idx_q;
  assign LAST          = last_v;
  assign BUSY          = (state_v != IDLE);
  assign DONE          = done_v;
  assign TMR_ERR_COUNT = err_v;

endmodule

// File: tb/tb_fifo_unload_fsm_tmr.sv
// Bench for fifo_unload_fsm_tmr. A queue models the FWFT FIFO; the expected
// output stream of each event (data, channel, sample, last) is generated when
// the event's words are loaded and consumed as words are accepted.
module tb_fifo_unload_fsm_tmr;

  localparam int DW    = 16;
  localparam int NCHAN = 6;
  localparam int SW    = 7;
  localparam int W     = DW + 3 + SW + 1;

  logic          CLK        = 1'b0;
  logic          RST_N      = 1'b1;
  logic          START      = 1'b0;
  logic [SW-1:0] SAMP_MAX   = '0;
  logic          FIFO_EMPTY = 1'b1;
  logic [DW-1:0] FIFO_DOUT  = '0;
  logic          DOUT_READY = 1'b1;
  logic          RDENA;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;
  logic [2:0]    CHAN_IDX;
  logic [SW-1:0] SAMP_IDX;
  logic          LAST;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   TMR_ERR_COUNT;

  fifo_unload_fsm_tmr #(.DW(DW), .NCHAN(NCHAN), .SW(SW)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .START         (START),
    .SAMP_MAX      (SAMP_MAX),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .FIFO_DOUT     (FIFO_DOUT),
    .RDENA         (RDENA),
    .DOUT          (DOUT),
    .DOUT_VALID    (DOUT_VALID),
    .DOUT_READY    (DOUT_READY),
    .CHAN_IDX      (CHAN_IDX),
    .SAMP_IDX      (SAMP_IDX),
    .LAST          (LAST),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .TMR_ERR_COUNT (TMR_ERR_COUNT)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- state of the bench ----------------
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [W-1:0]  mon_e;
  int n_checks  = 0;
  int n_errors  = 0;
  int n_acc     = 0;
  int pops      = 0;
  int exp_total = 0;
  bit done_exp  = 1'b0;
  bit done_seen = 1'b0;
  bit mon_en    = 1'b0;
  bit rand_mode = 1'b0;
  bit gap       = 1'b0;
  bit rd_pending = 1'b0;
  logic [2:0][1:0]    st_f;
  logic [2:0][SW-1:0] sp_f;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void fifo_refresh();
    FIFO_EMPTY = gap || (fifo_q.size() == 0);
    FIFO_DOUT  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  // ---------------- FIFO model ----------------
  // Pop decision sampled late in the low phase, applied just after the edge.
  always @(negedge CLK) begin
    #4;
    rd_pending = RDENA;
    if (RDENA) check_eq("rdena_on_empty", FIFO_EMPTY, 0);
  end

  always @(posedge CLK) begin
    #1;
    if (rd_pending) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
      fifo_refresh();
    end
  end

  // ---------------- random drivers ----------------
  always @(negedge CLK) begin
    if (rand_mode) begin
      DOUT_READY = ($urandom_range(0, 3) != 0);
      gap        = ($urandom_range(0, 7) == 0);
      fifo_refresh();
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin
    #2;
    if (mon_en) begin
      check_eq("done", DONE, done_exp);
      if (DONE) done_seen = 1'b1;
      done_exp = 1'b0;
      if (DOUT_VALID && DOUT_READY) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          check_eq("extra_word", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("word", {DOUT, CHAN_IDX, SAMP_IDX, LAST}, mon_e);
          done_exp = mon_e[0];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_event(input int smax, input int base, input bit rnd);
    int total;
    logic [DW-1:0] w;
    total = (smax + 1) * NCHAN;
    for (int k = 0; k < total; k++) begin
      w = rnd ? DW'($urandom) : DW'(base + k);
      fifo_q.push_back(w);
      exp_q.push_back({w, 3'(k % NCHAN), SW'(k / NCHAN), 1'(k == total - 1)});
    end
    n_acc     = 0;
    pops      = 0;
    exp_total = total;
    fifo_refresh();
  endtask

  task automatic pulse_start(input int smax, input bit chk_lat);
    @(negedge CLK); #1;
    START    = 1'b1;
    SAMP_MAX = SW'(smax);
    @(negedge CLK); #1;
    START    = 1'b0;
    SAMP_MAX = SW'($urandom);
    if (chk_lat) begin
      #2;
      check_eq("lat_rdena", RDENA, 1);
      check_eq("lat_valid0", DOUT_VALID, 0);
      @(negedge CLK); #3;
      check_eq("lat_valid1", DOUT_VALID, 1);
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i;
    i = 0;
    do begin
      @(negedge CLK); #1;
      i++;
    end while (pops < n && i < budget);
    check_eq("wait_pops", pops, n);
  endtask

  task automatic finish_event(input int budget);
    int i;
    i = 0;
    while (!done_seen && i < budget) begin
      @(negedge CLK); #4;
      i++;
    end
    check_eq("done_timeout", done_seen, 1);
    check_eq("busy_after", BUSY, 0);
    check_eq("word_count", n_acc, exp_total);
    check_eq("exp_left", exp_q.size(), 0);
    done_seen = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    fifo_refresh();
    #1 RST_N = 1'b0;
    #2;
    check_eq("rst_valid", DOUT_VALID, 0);
    check_eq("rst_dout", DOUT, 0);
    check_eq("rst_chan", CHAN_IDX, 0);
    check_eq("rst_samp", SAMP_IDX, 0);
    check_eq("rst_last", LAST, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_rdena", RDENA, 0);
    check_eq("rst_err", TMR_ERR_COUNT, 0);
    @(negedge CLK); #1;
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // nominal two-sample event
    load_event(1, 'h100, 1'b0);
    pulse_start(1, 1'b1);
    finish_event(200);

    // backpressure on word 4
    load_event(1, 'h100, 1'b0);
    pulse_start(1, 1'b1);
    begin
      int i;
      i = 0;
      do begin
        @(negedge CLK); #1;
        i++;
      end while (!(DOUT_VALID && DOUT == 16'h0104) && i < 100);
    end
    check_eq("bp_reach", DOUT, 16'h0104);
    DOUT_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check_eq("bp_dout", DOUT, 16'h0104);
      check_eq("bp_chan", CHAN_IDX, 4);
      check_eq("bp_valid", DOUT_VALID, 1);
      check_eq("bp_rdena", RDENA, 0);
      @(negedge CLK); #1;
    end
    DOUT_READY = 1'b1;
    finish_event(200);

    // FIFO underrun after 7 words
    load_event(1, 'h100, 1'b0);
    pulse_start(1, 1'b1);
    wait_pops(7, 100);
    gap = 1'b1;
    fifo_refresh();
    for (int k = 0; k < 5; k++) begin
      #2;
      check_eq("gap_rdena", RDENA, 0);
      @(negedge CLK); #1;
    end
    gap = 1'b0;
    fifo_refresh();
    wait_pops(8, 20);
    #2;
    check_eq("gap_w8_chan", CHAN_IDX, 1);
    check_eq("gap_w8_samp", SAMP_IDX, 1);
    check_eq("gap_w8_dout", DOUT, 16'h0107);
    finish_event(200);

    // single-sample event
    load_event(0, 'h200, 1'b0);
    pulse_start(0, 1'b1);
    finish_event(100);

    // full-size event, random data, random backpressure/gaps, ignored START
    load_event(127, 0, 1'b1);
    pulse_start(127, 1'b1);
    rand_mode = 1'b1;
    repeat (50) @(negedge CLK);
    pulse_start(3, 1'b0);
    finish_event(8000);
    rand_mode  = 1'b0;
    gap        = 1'b0;
    DOUT_READY = 1'b1;
    fifo_refresh();

    // upsets on one copy of the state and sample counter
    check_eq("tmr_err0", TMR_ERR_COUNT, 0);
    load_event(1, 'h100, 1'b0);
    pulse_start(1, 1'b1);
    wait_pops(3, 50);
    st_f    = dut.state_q;
    st_f[1] = st_f[1] ^ 2'b11;
    force dut.state_q = st_f;
    #1 release dut.state_q;
    @(negedge CLK); #3;
    check_eq("tmr_err1", TMR_ERR_COUNT, 1);
    wait_pops(8, 50);
    sp_f    = dut.samp_q;
    sp_f[1] = sp_f[1] ^ SW'(1);
    force dut.samp_q = sp_f;
    #1 release dut.samp_q;
    @(negedge CLK); #3;
    check_eq("tmr_err2", TMR_ERR_COUNT, 2);
    finish_event(200);
    check_eq("tmr_err_end", TMR_ERR_COUNT, 2);

    // asynchronous reset in the middle of an event
    load_event(1, 'h300, 1'b0);
    pulse_start(1, 1'b0);
    wait_pops(5, 50);
    #2;
    mon_en = 1'b0;
    RST_N  = 1'b0;
    #1;
    check_eq("arst_valid", DOUT_VALID, 0);
    check_eq("arst_rdena", RDENA, 0);
    check_eq("arst_busy", BUSY, 0);
    check_eq("arst_err", TMR_ERR_COUNT, 0);
    check_eq("arst_dout", DOUT, 0);
    fifo_q.delete();
    exp_q.delete();
    done_exp  = 1'b0;
    done_seen = 1'b0;
    fifo_refresh();
    @(negedge CLK); #1;
    RST_N  = 1'b1;
    mon_en = 1'b1;
    load_event(0, 'h400, 1'b0);
    pulse_start(0, 1'b1);
    finish_event(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
